// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit(s).
// Optional even-parity bit after the data is enabled by defining PISO_SERIAL_TX_PARITY_EN.
module piso_serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             done
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CycLast  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] DataLast = BW'(WIDTH - 1);
    localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef PISO_SERIAL_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef PISO_SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cyc_q == CycLast);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
`ifdef PISO_SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (load) begin
                    shreg_d = din;
                    state_d = StStart;
`ifdef PISO_SERIAL_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == DataLast) begin
`ifdef PISO_SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef PISO_SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                // bit_q counts stop bits here; it was cleared on entry
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == StopLast) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) bit_d = '0;

        if (state_q == StIdle || state_d != state_q || bit_end) begin
            cyc_d = '0;
        end else begin
            cyc_d = cyc_q + 1'b1;
        end

        // Registered line value follows the state being entered, so sout lines up with state_q
        case (state_d)
            StStart:  sout_d = 1'b0;
            StData:   sout_d = shreg_d[0];
`ifdef PISO_SERIAL_TX_PARITY_EN
            StParity: sout_d = par_d;
`endif
            default:  sout_d = 1'b1;
        endcase

        done_d = (state_q != StIdle) && (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            sout_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

`ifdef PISO_SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign ready = (state_q == StIdle);
    assign busy  = ~ready;
    assign sout  = sout_q;
    assign done  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: one 8/1/1 instance and one 8/3/2 instance, table-driven plus random
// frames against a bit-list frame model.
module tb_piso_serial_tx;

`ifdef PISO_SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic       ready_a, busy_a, sout_a, done_a;
    logic       ready_b, busy_b, sout_b, done_b;
    logic       cur_sel = 1'b0;
    logic       ready_m, busy_m, sout_m, done_m;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .load(load_a),
        .ready(ready_a), .busy(busy_a), .sout(sout_a), .done(done_a)
    );

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(3), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .load(load_b),
        .ready(ready_b), .busy(busy_b), .sout(sout_b), .done(done_b)
    );

    assign ready_m = cur_sel ? ready_b : ready_a;
    assign busy_m  = cur_sel ? busy_b  : busy_a;
    assign sout_m  = cur_sel ? sout_b  : sout_a;
    assign done_m  = cur_sel ? done_b  : done_a;

    typedef struct {
        bit         sel;
        logic [7:0] din;
        logic       par;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input bit ok, input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic int frame_len(input bit sel);
        return (1 + 8 + P + (sel ? 2 : 1)) * (sel ? 3 : 1);
    endfunction

    // Expected sout per cycle after accept (index 0 = first cycle), built from the frame bit list
    function automatic logic [63:0] model_frame(input bit sel, input logic [7:0] d, input logic par);
        logic [63:0] v;
        int bc;
        int nb;
        v  = '1;
        bc = sel ? 3 : 1;
        nb = 1 + 8 + P + (sel ? 2 : 1);
        for (int i = 0; i < nb * bc; i++) begin
            int b;
            b = i / bc;
            if (b == 0) v[i] = 1'b0;
            else if (b <= 8) v[i] = d[b-1];
            else if (P == 1 && b == 9) v[i] = par;
            else v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic drive(input bit sel, input logic [7:0] d, input logic ld);
        if (sel) begin
            din_b = d; load_b = ld;
        end else begin
            din_a = d; load_a = ld;
        end
    endtask

    task automatic run_frame(input bit sel, input logic [7:0] d, input logic par,
                             input string name);
        logic [63:0] got, exp, mask;
        int len;
        bit busy_ok, done_ok;
        cur_sel = sel;
        len     = frame_len(sel);
        exp     = model_frame(sel, d, par);
        mask    = (64'd1 << len) - 64'd1;
        got     = '0;
        busy_ok = 1'b1;
        done_ok = 1'b1;
        @(negedge clk);
        check(ready_m === 1'b1 && busy_m === 1'b0, {name, " ready before load"},
              {62'd0, ready_m, busy_m}, 64'd2);
        drive(sel, d, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, ~d, 1'b0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            got[i] = sout_m;
            if (busy_m !== 1'b1 || ready_m !== 1'b0) busy_ok = 1'b0;
            if (done_m !== 1'b0) done_ok = 1'b0;
        end
        check((got & mask) === (exp & mask), {name, " sout frame"}, got & mask, exp & mask);
        check(busy_ok && done_ok, {name, " busy high, done low in frame"},
              {62'd0, busy_ok, done_ok}, 64'd3);
        @(negedge clk);
        check(done_m === 1'b1 && ready_m === 1'b1 && sout_m === 1'b1, {name, " done pulse"},
              {61'd0, done_m, ready_m, sout_m}, 64'd7);
    endtask

    initial begin
        logic [63:0] got, exp;
        int          len;
        bit          ok;
        logic [7:0]  r;

        tbl[0] = '{sel: 1'b0, din: 8'hA5, par: 1'b0};
        tbl[1] = '{sel: 1'b0, din: 8'h07, par: 1'b1};
        tbl[2] = '{sel: 1'b0, din: 8'hFF, par: 1'b0};
        tbl[3] = '{sel: 1'b0, din: 8'h00, par: 1'b0};
        tbl[4] = '{sel: 1'b0, din: 8'h80, par: 1'b1};
        tbl[5] = '{sel: 1'b0, din: 8'h5B, par: 1'b1};
        tbl[6] = '{sel: 1'b1, din: 8'h01, par: 1'b1};
        tbl[7] = '{sel: 1'b1, din: 8'hC3, par: 1'b0};
        tbl[8] = '{sel: 1'b1, din: 8'h70, par: 1'b1};

        #2 rst = 1'b1;
        #5;
        check(sout_a === 1'b1 && ready_a === 1'b1 && busy_a === 1'b0 && done_a === 1'b0,
              "reset outputs a", {60'd0, sout_a, ready_a, busy_a, done_a}, 64'hC);
        check(sout_b === 1'b1 && ready_b === 1'b1 && busy_b === 1'b0 && done_b === 1'b0,
              "reset outputs b", {60'd0, sout_b, ready_b, busy_b, done_b}, 64'hC);
        @(negedge clk);
        rst = 1'b0;
        ok  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sout_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
                sout_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0)
                ok = 1'b0;
        end
        check(ok, "idle 20 cycles", {63'd0, ok}, 64'd1);

        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].sel, tbl[i].din, tbl[i].par, $sformatf("vec%0d", i));
        end

        // Back-to-back with load held; din changes mid-frame must not disturb frame one
        cur_sel = 1'b0;
        len     = frame_len(1'b0);
        @(negedge clk);
        din_a  = 8'hFF;
        load_a = 1'b1;
        got    = '0;
        ok     = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            got[i] = sout_a;
            if (busy_a !== 1'b1) ok = 1'b0;
            if (i == 3) din_a = 8'h00;
        end
        exp = model_frame(1'b0, 8'hFF, 1'b0);
        check(got === (exp & ((64'd1 << len) - 64'd1)), "b2b frame FF", got,
              exp & ((64'd1 << len) - 64'd1));
        check(ok, "b2b busy through frame one", {63'd0, ok}, 64'd1);
        @(negedge clk);
        check(done_a === 1'b1 && ready_a === 1'b1, "b2b done cycle",
              {62'd0, done_a, ready_a}, 64'd3);
        got = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            got[i] = sout_a;
            if (i == 0) begin
                check(busy_a === 1'b1, "b2b second accepted on done", {63'd0, busy_a}, 64'd1);
                load_a = 1'b0;
            end
        end
        exp = model_frame(1'b0, 8'h00, 1'b0);
        check(got === (exp & ((64'd1 << len) - 64'd1)), "b2b frame 00", got,
              exp & ((64'd1 << len) - 64'd1));
        @(negedge clk);
        check(done_a === 1'b1, "b2b second done", {63'd0, done_a}, 64'd1);

        // Reset during data bit 3 of 8'h00
        @(negedge clk);
        din_a  = 8'h00;
        load_a = 1'b1;
        @(posedge clk);
        #1 load_a = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check(sout_a === 1'b0 && busy_a === 1'b1, "pre-reset data bit 3",
              {62'd0, sout_a, busy_a}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check(sout_a === 1'b1 && ready_a === 1'b1, "async reset sout",
              {62'd0, sout_a, ready_a}, 64'd3);
        @(negedge clk);
        rst = 1'b0;
        ok  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || ready_a !== 1'b1 || sout_a !== 1'b1) ok = 1'b0;
        end
        check(ok, "no done after aborted frame", {63'd0, ok}, 64'd1);
        run_frame(1'b0, 8'h3C, 1'b0, "after reset 3C");

        // Random frames with random idle gaps
        for (int i = 0; i < 16; i++) begin
            bit s;
            s = (i % 4 == 3);
            r = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(s, r, ^r, $sformatf("rand%0d din=%h", i, r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out framed transmitter that feeds the serial input of the team's right-shift register chains.
- Accepts a WIDTH-bit word through a ready/load handshake.
- Emits one frame on sout, LSB first (right-shift order): start bit (0), data bits, optional parity, then stop bit(s) (1).
- sout idles high; each bit is held for BIT_CYCLES clocks.

Parameters:
WIDTH, 8, data bits per frame (>=1)
BIT_CYCLES, 1, clocks each serial bit is held (>=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
din  input  WIDTH  parallel word to send
load  input  1  request to send din; accepted only when ready=1
ready  output  1  high when idle and able to accept load
busy  output  1  high while a frame is in progress (not IDLE)
sout  output  1  serial line, idle high
done  output  1  one-cycle pulse on the first IDLE cycle after a frame

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: state=IDLE, sout=1, ready=1, busy=0, done=0, shift register=0, counters=0.
- States: IDLE, START, DATA, PARITY (only if PARITY_EN), STOP.
- ready and busy are decoded from state: ready = (state==IDLE), busy = ~ready.
- sout is a registered output.
- IDLE:
  - sout=1.
  - On load&&ready at a rising edge: capture din into the shift register and go to START.
  - sout=0 from the next cycle, so latency is 1 clock from accept to the start bit.
- START: sout=0 for BIT_CYCLES clocks, then DATA.
- DATA:
  - sout=shreg[0].
  - After every BIT_CYCLES clocks: shreg right-shifts with 0 fill and the bit counter increments.
  - After WIDTH bits: go to PARITY if enabled, otherwise STOP.
- STOP: sout=1 for STOP_BITS*BIT_CYCLES clocks, then IDLE.
- done:
  - Registered, high for exactly one cycle: the first cycle back in IDLE.
  - A load presented in that same cycle is accepted, giving back-to-back frames with no extra idle bit.
- Frame length: (1+WIDTH+P+STOP_BITS)*BIT_CYCLES clocks, where P=1 with PARITY_EN and 0 without.
- load while busy=1: ignored. No queuing, and din changes have no effect on the current frame.
- Bit-time counter: width clog2(BIT_CYCLES), minimum 1 bit. Resets to 0 at each bit boundary and on every state change.
- Bit counter: width clog2(WIDTH+1).
- rst mid-frame: sout goes to 1 immediately (asynchronously). The frame is aborted, no done pulse is issued, and ready=1 after reset release.
- load held continuously: a new frame starts on every done cycle.

Optional Feature:
Macro: PISO_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state follows DATA for BIT_CYCLES clocks, with sout = even parity (XOR of the captured din). The parity value is latched when the word is accepted.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
1. Reset/idle: rst=1 then 0, no load -> sout=1, ready=1, busy=0, done=0 for 20 cycles.
2. Basic frame (WIDTH=8, BIT_CYCLES=1, no parity): din=8'hA5 with a one-cycle load.
   - sout over 10 cycles = 0,1,0,1,0,0,1,0,1,1.
   - done pulses on cycle 11 after accept.
   - busy is high for 10 cycles.
3. Parity (macro defined): din=8'h07 -> data 1,1,1,0,0,0,0,0, parity bit 1, stop 1, frame of 11 cycles. din=8'hA5 -> parity bit 0.
4. Bit stretching (BIT_CYCLES=3, STOP_BITS=2): din=8'h01 -> start low 3 cycles, bit0 high 3 cycles, bits1-7 low 21 cycles, stop high 6 cycles; 33 cycles total.
5. Busy/back-to-back: load=1 held with din=8'hFF and then din=8'h00 changed mid-frame.
   - The first frame sends all 1s.
   - The second frame is accepted on the done cycle and sends all 0s.
   - No load is accepted while busy=1.
6. Reset mid-frame: assert rst during DATA bit 3 of din=8'h00 -> sout=1 asynchronously, no done pulse; after release a new load of 8'h3C transmits correctly.
